// File: rtl/mandel_render_ctrl_if.sv
// mandel_render_ctrl_if: serial config, engine dispatch and framebuffer signals of the render controller
interface mandel_render_ctrl_if #(
  parameter int N_ENG = 2,
  parameter int CTRWIDTH = 10,
  parameter int WIDTH = 400,
  parameter int HEIGHT = 300,
  parameter int CFG_WIDTH = 53
);
  logic sen;
  logic sclk;
  logic sdata;
  logic [CFG_WIDTH-1:0] cfg;
  logic [N_ENG-1:0] eng_run;
  logic [$clog2(WIDTH)-1:0] pix_x;
  logic [$clog2(HEIGHT)-1:0] pix_y;
  logic [N_ENG-1:0] eng_done;
  logic [N_ENG*CTRWIDTH-1:0] eng_ctr;
  logic fb_reset_ptr;
  logic fb_write;
  logic [CTRWIDTH-1:0] fb_data;
  logic fb_wrote;
  logic running;
  logic finished;
  modport master (
    input sen, sclk, sdata, eng_done, eng_ctr, fb_wrote,
    output cfg, eng_run, pix_x, pix_y, fb_reset_ptr, fb_write, fb_data, running, finished
  );
  modport slave (
    output sen, sclk, sdata, eng_done, eng_ctr, fb_wrote,
    input cfg, eng_run, pix_x, pix_y, fb_reset_ptr, fb_write, fb_data, running, finished
  );
endinterface

// File: rtl/mandel_render_ctrl.sv
// mandel_render_ctrl: serial-configured frame controller dispatching pixels round-robin and retiring in raster order
module mandel_render_ctrl #(
  parameter int N_ENG = 2,
  parameter int CTRWIDTH = 10,
  parameter int WIDTH = 400,
  parameter int HEIGHT = 300,
  parameter int CFG_WIDTH = 53,
  parameter int SYNC_STAGES = 3
) (
  input logic clk,
  input logic rst,
  mandel_render_ctrl_if.master bus
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int PW = N_ENG > 1 ? $clog2(N_ENG) : 1;
  localparam int NW = $clog2(TOTAL + 1);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
  typedef enum logic [1:0] {FREE, BUSY, HOLD} slot_t;
  state_t state, state_nxt;
  slot_t slot [N_ENG];
  logic [CTRWIDTH-1:0] res [N_ENG];
  logic [SYNC_STAGES-1:0] sen_q, sclk_q, sdata_q;
  logic [PW-1:0] iss_ptr, ret_ptr;
  logic [NW-1:0] issued, retired;
  logic pend, issue, retire, start_ev, shift;
  assign shift = sclk_q[SYNC_STAGES-2] & ~sclk_q[SYNC_STAGES-1] & sen_q[SYNC_STAGES-2];
  assign start_ev = sen_q[SYNC_STAGES-1] & ~sen_q[SYNC_STAGES-2];
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    issue = state == RUN && issued < NW'(TOTAL) && slot[iss_ptr] == FREE;
    retire = state == RUN && slot[ret_ptr] == HOLD && !pend;
    bus.eng_run = issue ? N_ENG'(1) << iss_ptr : '0;
    bus.fb_reset_ptr = state == START;
    bus.fb_write = retire;
    bus.fb_data = res[ret_ptr];
    state_nxt = state == IDLE ? (start_ev ? START : IDLE) :
                state == START ? RUN :
                (retired == NW'(TOTAL) ? IDLE : RUN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sen_q <= '0;
      sclk_q <= '0;
      sdata_q <= '0;
      bus.cfg <= '0;
      bus.pix_x <= '0;
      bus.pix_y <= '0;
      bus.running <= 1'b0;
      bus.finished <= 1'b0;
      pend <= 1'b0;
      iss_ptr <= '0;
      ret_ptr <= '0;
      issued <= '0;
      retired <= '0;
      for (int k = 0; k < N_ENG; k++) begin
        slot[k] <= FREE;
        res[k] <= '0;
      end
    end else begin
      sen_q <= {sen_q[SYNC_STAGES-2:0], bus.sen};
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.sclk};
      sdata_q <= {sdata_q[SYNC_STAGES-2:0], bus.sdata};
      if (shift) bus.cfg <= {sdata_q[SYNC_STAGES-1], bus.cfg[CFG_WIDTH-1:1]};
      if (state == START) begin
        bus.finished <= 1'b0;
        bus.running <= 1'b1;
        bus.pix_x <= '0;
        bus.pix_y <= '0;
        pend <= 1'b0;
        iss_ptr <= '0;
        ret_ptr <= '0;
        issued <= '0;
        retired <= '0;
        for (int k = 0; k < N_ENG; k++) slot[k] <= FREE;
      end else if (state == RUN) begin
        if (retired == NW'(TOTAL)) begin
          bus.running <= 1'b0;
          bus.finished <= 1'b1;
        end
        for (int k = 0; k < N_ENG; k++)
          if (bus.eng_done[k] && slot[k] == BUSY) begin
            slot[k] <= HOLD;
            res[k] <= bus.eng_ctr[k*CTRWIDTH +: CTRWIDTH];
          end
        if (issue) begin
          slot[iss_ptr] <= BUSY;
          iss_ptr <= iss_ptr == PW'(N_ENG - 1) ? '0 : iss_ptr + 1'b1;
          issued <= issued + 1'b1;
          bus.pix_x <= bus.pix_x == XW'(WIDTH - 1) ? '0 : bus.pix_x + 1'b1;
          if (bus.pix_x == XW'(WIDTH - 1))
            bus.pix_y <= bus.pix_y == YW'(HEIGHT - 1) ? '0 : bus.pix_y + 1'b1;
        end
        if (retire) pend <= 1'b1;
        if (bus.fb_wrote && pend) begin
          pend <= 1'b0;
          slot[ret_ptr] <= FREE;
          ret_ptr <= ret_ptr == PW'(N_ENG - 1) ? '0 : ret_ptr + 1'b1;
          retired <= retired + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_mandel_render_ctrl.sv
// tb_mandel_render_ctrl: scoreboard bench with behavioural engines and framebuffer for a 4x2 frame
module tb_mandel_render_ctrl;
  localparam int N_ENG = 2, CTRWIDTH = 10, WIDTH = 4, HEIGHT = 2, CFG_WIDTH = 53, SYNC_STAGES = 3;
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int XW = $clog2(WIDTH), YW = $clog2(HEIGHT);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mandel_render_ctrl_if #(.N_ENG(N_ENG), .CTRWIDTH(CTRWIDTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CFG_WIDTH(CFG_WIDTH)) bus();
  mandel_render_ctrl #(.N_ENG(N_ENG), .CTRWIDTH(CTRWIDTH), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .CFG_WIDTH(CFG_WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  int checks = 0, errors = 0;
  int cyc = 0, idx, retired, nwrites, inflight, rp_count, rp_cyc, ack_delay, ack_cnt, held;
  int cnt [N_ENG];
  int val [N_ENG];
  int lat [N_ENG];
  bit pending, spur;
  int exp_q [$];
  task automatic model_reset();
    idx = 0; retired = 0; nwrites = 0; inflight = 0; rp_count = 0; rp_cyc = -10;
    pending = 0; ack_cnt = 0; held = 0;
    exp_q.delete();
    for (int k = 0; k < N_ENG; k++) begin cnt[k] = 0; val[k] = 0; end
  endtask
  task automatic cycle();
    logic [N_ENG-1:0] done, exp_run;
    logic [N_ENG*CTRWIDTH-1:0] ctr;
    logic wrote;
    int e;
    @(negedge clk);
    cyc++;
    done = '0; ctr = '0; wrote = 1'b0;
    if (bus.fb_reset_ptr) begin rp_count++; rp_cyc = cyc; end
    for (int k = 0; k < N_ENG; k++)
      if (cnt[k] > 0) begin
        cnt[k]--;
        if (cnt[k] == 0) begin done[k] = 1'b1; ctr[k*CTRWIDTH +: CTRWIDTH] = CTRWIDTH'(val[k]); end
      end
    if (bus.eng_run != '0) begin
      e = idx % N_ENG;
      exp_run = N_ENG'(1) << e;
      checks++;
      if (bus.eng_run !== exp_run) begin errors++; $display("FAIL eng_run pixel %0d: got %b want %b", idx, bus.eng_run, exp_run); end
      checks++;
      if (bus.pix_x !== XW'(idx % WIDTH) || bus.pix_y !== YW'(idx / WIDTH)) begin
        errors++; $display("FAIL pix_xy pixel %0d: got (%0d,%0d) want (%0d,%0d)", idx, bus.pix_x, bus.pix_y, idx % WIDTH, idx / WIDTH);
      end
      if (idx == 0) begin
        checks++;
        if (rp_count !== 1 || rp_cyc !== cyc - 1 || bus.running !== 1'b1 || bus.finished !== 1'b0) begin
          errors++; $display("FAIL frame_start: rp_count %0d rp_cyc %0d cyc %0d running %b finished %b, want 1, cyc-1, 1, 0",
            rp_count, rp_cyc, cyc, bus.running, bus.finished);
        end
      end
      cnt[e] = lat[e]; val[e] = idx;
      exp_q.push_back(idx);
      idx++; inflight++;
      checks++;
      if (inflight > N_ENG) begin errors++; $display("FAIL inflight: got %0d want <= %0d", inflight, N_ENG); end
    end
    if (bus.fb_write) begin
      checks++;
      if (pending || exp_q.size() == 0) begin
        errors++; $display("FAIL fb_write_extra: got write with pending %b queue %0d, want none", pending, exp_q.size());
      end else begin
        checks++;
        if (bus.fb_data !== CTRWIDTH'(exp_q[0])) begin errors++; $display("FAIL fb_data: got %0d want %0d", bus.fb_data, exp_q[0]); end
      end
      pending = 1; held = int'(bus.fb_data); ack_cnt = ack_delay; nwrites++;
    end else if (pending) begin
      checks++;
      if (bus.fb_data !== CTRWIDTH'(held)) begin errors++; $display("FAIL fb_data_stable: got %0d want %0d", bus.fb_data, held); end
      if (ack_cnt == 0) begin
        wrote = 1'b1; pending = 0; inflight--; retired++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else ack_cnt--;
    end else if (spur && cyc % 3 == 0) wrote = 1'b1;
    if (spur)
      for (int k = 0; k < N_ENG; k++)
        if (cnt[k] == 0 && !done[k]) begin done[k] = 1'b1; ctr[k*CTRWIDTH +: CTRWIDTH] = 10'h3A5; end
    bus.eng_done = done; bus.eng_ctr = ctr; bus.fb_wrote = wrote;
  endtask
  task automatic start_frame();
    model_reset();
    bus.sen = 1'b1;
    repeat (5) cycle();
    bus.sen = 1'b0;
  endtask
  task automatic run_until(input int n, input int budget);
    int i = 0;
    while (retired < n && i < budget) begin cycle(); i++; end
    checks++;
    if (retired < n) begin errors++; $display("FAIL timeout: retired %0d want %0d", retired, n); end
  endtask
  task automatic finish_frame(input string name);
    cycle();
    cycle();
    checks++;
    if (bus.running !== 1'b0 || bus.finished !== 1'b1) begin
      errors++; $display("FAIL %s_end: running %b finished %b want 0 1", name, bus.running, bus.finished);
    end
    checks++;
    if (nwrites !== TOTAL || idx !== TOTAL || rp_count !== 1 || exp_q.size() !== 0) begin
      errors++; $display("FAIL %s_counts: writes %0d issues %0d reset_ptr %0d left %0d want %0d %0d 1 0",
        name, nwrites, idx, rp_count, exp_q.size(), TOTAL, TOTAL);
    end
  endtask
  task automatic check_idle_outputs(input string name, input bit with_cfg);
    checks++;
    if ((with_cfg && bus.cfg !== '0) || bus.eng_run !== '0 || bus.pix_x !== '0 || bus.pix_y !== '0) begin
      errors++; $display("FAIL %s_dispatch: cfg %h eng_run %b pix (%0d,%0d) want 0", name, bus.cfg, bus.eng_run, bus.pix_x, bus.pix_y);
    end
    checks++;
    if (bus.fb_reset_ptr !== 1'b0 || bus.fb_write !== 1'b0 || bus.fb_data !== '0) begin
      errors++; $display("FAIL %s_fb: reset_ptr %b write %b data %0d want 0", name, bus.fb_reset_ptr, bus.fb_write, bus.fb_data);
    end
    checks++;
    if (bus.running !== 1'b0 || bus.finished !== 1'b0) begin
      errors++; $display("FAIL %s_status: running %b finished %b want 0 0", name, bus.running, bus.finished);
    end
  endtask
  task automatic test_reset();
    bus.sen = 1'b0; bus.sclk = 1'b0; bus.sdata = 1'b0;
    bus.eng_done = '0; bus.eng_ctr = '0; bus.fb_wrote = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_config();
    logic [CFG_WIDTH-1:0] v = 53'h1A5A5A0F0F3C3C;
    bus.sen = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < CFG_WIDTH; i++) begin
      bus.sdata = v[i]; bus.sclk = 1'b0;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
    end
    bus.sclk = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.cfg !== v) begin errors++; $display("FAIL cfg_load: got %h want %h", bus.cfg, v); end
    bus.sen = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.sdata = ~bus.sdata; bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    checks++;
    if (bus.cfg !== v) begin errors++; $display("FAIL cfg_hold: got %h want %h", bus.cfg, v); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_order_skew();
    lat[0] = 10; lat[1] = 2; ack_delay = 0; spur = 0;
    start_frame();
    run_until(TOTAL, 600);
    finish_frame("order");
  endtask
  task automatic test_back_pressure();
    checks++;
    if (bus.finished !== 1'b1) begin errors++; $display("FAIL finished_hold: got %b want 1", bus.finished); end
    lat[0] = 3; lat[1] = 5; ack_delay = 6; spur = 0;
    start_frame();
    run_until(TOTAL, 1000);
    finish_frame("backpressure");
  endtask
  task automatic test_spurious();
    int i = 0;
    lat[0] = 10; lat[1] = 2; ack_delay = 1; spur = 1;
    start_frame();
    while (retired < TOTAL && i < 1000) begin
      cycle();
      i++;
      if (i == 10) bus.sen = 1'b1;
      if (i == 16) bus.sen = 1'b0;
    end
    checks++;
    if (retired < TOTAL) begin errors++; $display("FAIL spurious_timeout: retired %0d want %0d", retired, TOTAL); end
    spur = 0;
    finish_frame("spurious");
  endtask
  task automatic test_reset_midframe();
    lat[0] = 2; lat[1] = 3; ack_delay = 0; spur = 0;
    start_frame();
    run_until(3, 300);
    rst = 1'b1;
    #1;
    check_idle_outputs("midreset", 1'b0);
    bus.eng_done = '0; bus.fb_wrote = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_frame();
    run_until(TOTAL, 600);
    finish_frame("rerun");
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    model_reset();
    lat[0] = 1; lat[1] = 1; ack_delay = 0; spur = 0;
    test_reset();
    test_config();
    test_order_skew();
    test_back_pressure();
    test_spurious();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
